qsn_shift_sequencer: RTL and testbench
======================================

# qsn_shift_sequencer

Upstream feeder for the 3-length QSN controller in the partial message-passing datapath. Holds a programmable base-matrix shift table of `LAYER_NUM × COL_NUM` circulant entries and replays it layer by layer, column by column, for a requested number of decoding iterations. Each entry goes out as a `shift_factor` beat under valid/ready flow control, with its layer, column and iteration indices attached. The QSN controller turns each beat into its left, right and merge selects.

## Interface
Parameters:
- `PERMUTATION_LENGTH`, 3, circulant size; `shift_factor` width is `$clog2(PERMUTATION_LENGTH)` = 2
- `LAYER_NUM`, 3, layers per frame
- `COL_NUM`, 4, submatrix columns per layer
- `ITER_W`, 4, iteration counter width

Ports:
- `sys_clk`  in  1  system clock; all logic on its rising edge
- `rstn`  in  1  asynchronous active-low reset
- `cfg_we`  in  1  table write strobe
- `cfg_addr`  in  4  table address, `layer*COL_NUM+col`
- `cfg_shift`  in  2  shift value to store
- `cfg_null`  in  1  entry is a zero submatrix
- `start`  in  1  begin a run; accepted only when `busy`=0
- `iter_max`  in  `ITER_W`  iterations to run; latched at start; 0 is treated as 1
- `abort`  in  1  terminate the current run
- `shift_ready`  in  1  downstream accepts the beat
- `shift_valid`  out  1  beat valid
- `shift_factor`  out  2  circulant shift of the current entry
- `shift_null`  out  1  null flag of the current entry
- `layer_id`  out  2  layer index of the beat
- `col_id`  out  2  column index of the beat
- `iter_id`  out  `ITER_W`  iteration index of the beat
- `layer_last`  out  1  beat is the last column of its layer
- `frame_last`  out  1  beat is the final beat of the run
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse on normal completion
- `cfg_err`  out  1  sticky flag for rejected configuration writes

## Operation
- On reset:
  - All outputs are 0 and the FSM is in IDLE.
  - All table entries are shift 0, null 0.
- Table write:
  - Performed on `cfg_we` in IDLE when no start is accepted in the same cycle.
  - The write is rejected, and `cfg_err` set, if any of the following holds:
    - `cfg_shift` ≥ `PERMUTATION_LENGTH`
    - `cfg_addr` ≥ `LAYER_NUM*COL_NUM`
    - the FSM is in RUN
    - `start` is accepted in the same cycle
  - `cfg_err` clears only on reset.
- FSM states are IDLE and RUN.
- IDLE → RUN on `start`:
  - Latch `max(iter_max,1)`.
  - Load the output registers with entry (layer 0, col 0, iter 0).
  - Set `shift_valid`=1 and `busy`=1.
- In RUN, a handshake occurs when `shift_valid` & `shift_ready`. On a handshake, advance to the next beat:
  - col increments;
  - when col wraps from `COL_NUM-1` to 0, layer increments;
  - when layer wraps from `LAYER_NUM-1` to 0, iter increments.
- In RUN without a handshake, all beat outputs hold stable.
- Flag definitions:
  - `layer_last` = (col == `COL_NUM-1`).
  - `frame_last` = `layer_last` & (layer == `LAYER_NUM-1`) & (iter == latched max − 1).
- Handshake on a `frame_last` beat:
  - The next state is IDLE.
  - `shift_valid`, `busy` and the beat outputs go to 0.
  - `done` pulses for 1 cycle.
- `abort` in RUN:
  - The next state is IDLE, with `shift_valid`=0 and `busy`=0.
  - There is no `done` pulse.
  - `abort` takes priority over a simultaneous handshake.
  - `abort` in IDLE has no effect.
- `start` while `busy` is ignored.
- `abort` and `start` in the same IDLE cycle: `start` is accepted.
- A run always makes exactly `LAYER_NUM*COL_NUM*max(iter_max,1)` handshakes, read from the table contents at beat time.
- `rstn` asserted mid-run aborts immediately and asynchronously to the reset state. Table contents are lost and return to zero.

## Timing
- `start` accepted at cycle t: `shift_valid`=1 at t+1 with (0,0,0).
- Handshake at cycle t: the next beat is presented at t+1. Sustained `shift_ready`=1 gives 1 beat per cycle.
- Final handshake at cycle T:
  - `shift_valid`=0, `busy`=0, `done`=1 at T+1.
  - `done`=0 at T+2.
  - A new `start` is accepted at T+1.
- `abort` at cycle t: `shift_valid`=0 and `busy`=0 at t+1.
- Table write at cycle t is visible to any beat loaded at t+1 or later.
- All outputs are registered; no combinational path from `shift_ready` to any output.

## Test plan
- Reset, then check every output is 0 and `cfg_err`=0. Write entries 0..11 with shift = addr mod 3 and null = (addr==5). Start with `iter_max`=1 and `shift_ready`=1 → 12 consecutive beats with `shift_factor` sequence 0,1,2,0,…; `shift_null`=1 on beat 5; `layer_last` on beats 3, 7, 11; `frame_last` on beat 11; `done` one cycle after beat 11.
- `iter_max`=0 → exactly 12 beats (treated as 1). `iter_max`=3 → 36 beats; `iter_id` steps 0→1→2 at beats 12 and 24.
- Backpressure: toggle `shift_ready` 1,0,0,1 repeatedly → outputs frozen during ready=0; the beat order is identical to the ungated run; beat count stays 12.
- `cfg_we` with `cfg_shift`=3, `cfg_addr`=12, or during RUN → no table change, `cfg_err`=1 until reset. `start` while busy → ignored; run length unchanged.
- `abort` on beat 4 together with `shift_ready`=1 → `shift_valid`=0 next cycle, no `done`. An immediate restart begins at (0,0,0).
- Assert `rstn` mid-run → all outputs 0 asynchronously. After release, start with `iter_max`=1 → all `shift_factor` beats are 0.

Source files
------------

// File: rtl/qsn_shift_sequencer.sv
// Replays a programmable LAYER_NUM x COL_NUM circulant shift table as a stream of
// valid/ready beats, layer by layer and column by column, for a requested iteration count.
module qsn_shift_sequencer #(
  parameter int PERMUTATION_LENGTH = 3,
  parameter int LAYER_NUM          = 3,
  parameter int COL_NUM            = 4,
  parameter int ITER_W             = 4,
  localparam int SHIFT_W = (PERMUTATION_LENGTH > 1) ? $clog2(PERMUTATION_LENGTH) : 1,
  localparam int ENTRIES = LAYER_NUM * COL_NUM,
  localparam int ADDR_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int LAYER_W = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1,
  localparam int COL_W   = (COL_NUM > 1) ? $clog2(COL_NUM) : 1
) (
  input  logic               sys_clk,
  input  logic               rstn,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_null,
  input  logic               start,
  input  logic [ITER_W-1:0]  iter_max,
  input  logic               abort,
  input  logic               shift_ready,
  output logic               shift_valid,
  output logic [SHIFT_W-1:0] shift_factor,
  output logic               shift_null,
  output logic [LAYER_W-1:0] layer_id,
  output logic [COL_W-1:0]   col_id,
  output logic [ITER_W-1:0]  iter_id,
  output logic               layer_last,
  output logic               frame_last,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COL_NUM - 1);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(LAYER_NUM - 1);

  state_t               state_q;
  logic [ITER_W-1:0]    iter_max_q;
  logic                 valid_q, busy_q, done_q, err_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic                 null_q, layer_last_q, frame_last_q;
  logic [LAYER_W-1:0]   layer_q;
  logic [COL_W-1:0]     col_q;
  logic [ITER_W-1:0]    iter_q;

  logic [SHIFT_W-1:0]   tbl_shift_q [ENTRIES];
  logic                 tbl_null_q  [ENTRIES];

  logic                 start_acc, cfg_bad, wr_en, handshake;
  logic [ITER_W-1:0]    iter_lim_d;
  logic [LAYER_W-1:0]   layer_d;
  logic [COL_W-1:0]     col_d;
  logic [ITER_W-1:0]    iter_d;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 layer_last_d, frame_last_d;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign handshake = valid_q && shift_ready;
  assign cfg_bad   = ({1'b0, cfg_shift} >= (SHIFT_W+1)'(PERMUTATION_LENGTH)) ||
                     ({1'b0, cfg_addr}  >= (ADDR_W+1)'(ENTRIES)) ||
                     (state_q == ST_RUN) || start_acc;
  assign wr_en     = cfg_we && !cfg_bad;

  // Next beat position: (0,0,0) when launching from IDLE, otherwise the successor of the current beat.
  always_comb begin
    iter_lim_d = iter_max_q;
    layer_d    = '0;
    col_d      = '0;
    iter_d     = '0;
    if (state_q == ST_IDLE) begin
      iter_lim_d = (iter_max == '0) ? ITER_W'(1) : iter_max;
    end else if (col_q != COL_LAST) begin
      col_d   = col_q + COL_W'(1);
      layer_d = layer_q;
      iter_d  = iter_q;
    end else if (layer_q != LAYER_LAST) begin
      layer_d = layer_q + LAYER_W'(1);
      iter_d  = iter_q;
    end else begin
      iter_d  = iter_q + ITER_W'(1);
    end
    rd_addr      = ADDR_W'(layer_d) * ADDR_W'(COL_NUM) + ADDR_W'(col_d);
    layer_last_d = (col_d == COL_LAST);
    frame_last_d = layer_last_d && (layer_d == LAYER_LAST) && (iter_d == iter_lim_d - ITER_W'(1));
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_tbl
      always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
          tbl_shift_q[gi] <= '0;
          tbl_null_q[gi]  <= 1'b0;
        end else if (wr_en && (cfg_addr == ADDR_W'(gi))) begin
          tbl_shift_q[gi] <= cfg_shift;
          tbl_null_q[gi]  <= cfg_null;
        end
      end
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      iter_max_q   <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      shift_q      <= '0;
      null_q       <= 1'b0;
      layer_q      <= '0;
      col_q        <= '0;
      iter_q       <= '0;
      layer_last_q <= 1'b0;
      frame_last_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= err_q | (cfg_we & cfg_bad);
      if (start_acc || (state_q == ST_RUN && !abort && handshake && !frame_last_q)) begin
        state_q      <= ST_RUN;
        valid_q      <= 1'b1;
        busy_q       <= 1'b1;
        shift_q      <= tbl_shift_q[rd_addr];
        null_q       <= tbl_null_q[rd_addr];
        layer_q      <= layer_d;
        col_q        <= col_d;
        iter_q       <= iter_d;
        layer_last_q <= layer_last_d;
        frame_last_q <= frame_last_d;
        if (start_acc) iter_max_q <= iter_lim_d;
      end else if (state_q == ST_RUN && (abort || handshake)) begin
        // Abort wins over a simultaneous handshake, so done only follows a clean final beat.
        state_q      <= ST_IDLE;
        valid_q      <= 1'b0;
        busy_q       <= 1'b0;
        done_q       <= !abort;
        shift_q      <= '0;
        null_q       <= 1'b0;
        layer_q      <= '0;
        col_q        <= '0;
        iter_q       <= '0;
        layer_last_q <= 1'b0;
        frame_last_q <= 1'b0;
      end
    end
  end

  assign shift_valid  = valid_q;
  assign shift_factor = shift_q;
  assign shift_null   = null_q;
  assign layer_id     = layer_q;
  assign col_id       = col_q;
  assign iter_id      = iter_q;
  assign layer_last   = layer_last_q;
  assign frame_last   = frame_last_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = err_q;

endmodule

// File: tb/tb_qsn_shift_sequencer.sv
// Scoreboard bench for qsn_shift_sequencer: expected beats are queued from a table model
// when a run is launched; a negedge monitor compares every presented beat against the queue.
module tb_qsn_shift_sequencer;

  localparam int PL = 3;
  localparam int LN = 3;
  localparam int CN = 4;
  localparam int IW = 4;
  localparam int NE = LN * CN;

  logic          sys_clk = 1'b0;
  logic          rstn, cfg_we, cfg_null, start, abort, shift_ready;
  logic [3:0]    cfg_addr;
  logic [1:0]    cfg_shift;
  logic [IW-1:0] iter_max;
  logic          shift_valid, shift_null, layer_last, frame_last, busy, done, cfg_err;
  logic [1:0]    shift_factor, layer_id, col_id;
  logic [IW-1:0] iter_id;

  qsn_shift_sequencer #(.PERMUTATION_LENGTH(PL), .LAYER_NUM(LN), .COL_NUM(CN), .ITER_W(IW)) dut (
    .sys_clk(sys_clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_shift(cfg_shift),
    .cfg_null(cfg_null), .start(start), .iter_max(iter_max), .abort(abort), .shift_ready(shift_ready),
    .shift_valid(shift_valid), .shift_factor(shift_factor), .shift_null(shift_null), .layer_id(layer_id),
    .col_id(col_id), .iter_id(iter_id), .layer_last(layer_last), .frame_last(frame_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [1:0]    sf;
    logic          nl;
    logic [1:0]    ly;
    logic [1:0]    cl;
    logic [IW-1:0] it;
    logic          ll;
    logic          fl;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      act_b;
  int         tests = 0;
  int         fails = 0;
  int         hs_count = 0;
  bit         expect_done = 1'b0;
  bit         exp_err = 1'b0;
  logic [1:0] model_shift [NE];
  bit         model_null  [NE];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Reference: a run is every (iter, layer, col) in nested order, flags from position alone.
  task automatic push_run(input int im);
    int n;
    beat_t b;
    n = (im == 0) ? 1 : im;
    for (int it = 0; it < n; it++)
      for (int l = 0; l < LN; l++)
        for (int c = 0; c < CN; c++) begin
          b.sf = model_shift[l*CN + c];
          b.nl = model_null[l*CN + c];
          b.ly = 2'(l);
          b.cl = 2'(c);
          b.it = IW'(it);
          b.ll = (c == CN - 1);
          b.fl = (c == CN - 1) && (l == LN - 1) && (it == n - 1);
          exp_q.push_back(b);
        end
  endtask

  always @(negedge sys_clk) begin
    if (rstn) begin
      if (expect_done) begin
        check("done_pulse", 32'(done), 32'd1);
        check("idle_after_done", {30'd0, shift_valid, busy}, 32'd0);
        expect_done = 1'b0;
      end else begin
        check("done_quiet", 32'(done), 32'd0);
      end
      if (shift_valid) begin
        act_b.sf = shift_factor;
        act_b.nl = shift_null;
        act_b.ly = layer_id;
        act_b.cl = col_id;
        act_b.it = iter_id;
        act_b.ll = layer_last;
        act_b.fl = frame_last;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_beat actual=%0h required=none", act_b);
        end else begin
          check($sformatf("beat%0d", hs_count), 32'(act_b), 32'(exp_q[0]));
          if (shift_ready && !abort) begin
            if (exp_q[0].fl) expect_done = 1'b1;
            void'(exp_q.pop_front());
            hs_count++;
          end
        end
      end
    end
  end

  task automatic cfg_write(input int a, input int s, input bit n);
    cfg_we = 1'b1; cfg_addr = a[3:0]; cfg_shift = s[1:0]; cfg_null = n;
    tick();
    cfg_we = 1'b0;
    if (a < NE && s < PL) begin
      model_shift[a] = s[1:0];
      model_null[a]  = n;
    end else begin
      exp_err = 1'b1;
    end
    check("cfg_err", 32'(cfg_err), 32'(exp_err));
  endtask

  // mode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic run(input int im, input int mode, input int abort_at, input bit mid_start, input bit mid_cfg);
    int cyc;
    int ph;
    bit was_abort;
    push_run(im);
    hs_count = 0;
    start = 1'b1; iter_max = im[IW-1:0]; shift_ready = 1'b0;
    tick();
    start = 1'b0;
    cyc = 0; ph = 0; was_abort = 1'b0;
    while (exp_q.size() > 0 && cyc < 600) begin
      case (mode)
        0:       shift_ready = 1'b1;
        1:       shift_ready = (ph % 4 == 0) || (ph % 4 == 3);
        default: shift_ready = 1'($urandom_range(0, 1));
      endcase
      ph++;
      abort     = (abort_at >= 0) && (hs_count == abort_at);
      start     = mid_start && (hs_count == 5);
      iter_max  = 4'd1;
      cfg_we    = mid_cfg && (hs_count == 3);
      cfg_addr  = 4'd0; cfg_shift = 2'd2; cfg_null = 1'b1;
      if (cfg_we) exp_err = 1'b1;
      was_abort = abort;
      tick();
      cyc++;
      if (was_abort) begin
        abort = 1'b0;
        check("abort_valid", 32'(shift_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
      end
    end
    abort = 1'b0; start = 1'b0; cfg_we = 1'b0;
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL run_timeout actual=%0d beats_left required=0", exp_q.size());
      exp_q.delete();
    end
    if (mid_cfg) check("cfg_err_run", 32'(cfg_err), 32'(exp_err));
  endtask

  task automatic check_all_zero(input string name);
    check(name, {13'd0, shift_valid, shift_factor, shift_null, layer_id, col_id, iter_id,
                 layer_last, frame_last, busy, done, cfg_err}, 32'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      model_shift[i] = 2'd0;
      model_null[i]  = 1'b0;
    end
    exp_err = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_shift = '0; cfg_null = 1'b0;
    start = 1'b0; iter_max = '0; abort = 1'b0; shift_ready = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset_outputs");
    tick();
    rstn = 1'b1;
    tick();

    for (int a = 0; a < NE; a++) cfg_write(a, a % 3, a == 5);
    run(1, 0, -1, 1'b0, 1'b0);
    run(0, 0, -1, 1'b0, 1'b0);
    run(3, 0, -1, 1'b0, 1'b0);
    run(1, 1, -1, 1'b0, 1'b0);

    cfg_write(0, 3, 1'b1);
    cfg_write(12, 1, 1'b0);
    run(3, 2, -1, 1'b1, 1'b1);

    run(1, 0, 4, 1'b0, 1'b0);
    run(1, 0, -1, 1'b0, 1'b0);

    for (int a = 0; a < NE; a++) cfg_write(a, int'($urandom_range(0, PL - 1)), 1'($urandom_range(0, 1)));
    run(2, 2, -1, 1'b0, 1'b0);
    run(1, 1, -1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a 3-iteration run.
    push_run(3);
    hs_count = 0;
    start = 1'b1; iter_max = 4'd3; shift_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    exp_q.delete();
    expect_done = 1'b0;
    model_reset();
    tick();
    rstn = 1'b1;
    tick();
    run(1, 0, -1, 1'b0, 1'b0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
